monitor_baterias_descargadas: RTL and testbench

Parametrised N-channel battery charge monitor with per-channel debounced state machine (NORMAL / BAJA / DESCARGADA), low-threshold hysteresis, sticky discharge alarm and aggregate outputs. Successor of the two-channel zero-charge detector; sits between the charge-level sampling logic and the indicator/alarm logic.

---
 rtl/monitor_baterias_descargadas.sv | 148 ++++++++++++++
 tb/tb_monitor_baterias_descargadas.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/monitor_baterias_descargadas.sv
// Battery charge monitor, N independent channels.
// Each channel classifies its charge level, debounces the target class over
// CICLOS_FILTRO consecutive cycles and holds a sticky alarm on discharge.
//
// Ports:
//   clk                    system clock, rising edge
//   rst_n                  asynchronous active-low reset
//   habilitar              monitor enable (low: states/alarms hold, filters cleared)
//   carga_baterias         packed charge levels, channel i at [i*ANCHO_CARGA +: ANCHO_CARGA]
//   borrar_alarma          per-channel sticky-alarm clear
//   advertencia_bateria    channel in DESCARGADA
//   bateria_baja           channel in BAJA
//   alarma_retenida        channel entered DESCARGADA since last clear
//   cualquier_advertencia  OR of advertencia_bateria
//   cuenta_descargadas     number of channels in DESCARGADA
//
// state      | meaning
// NORMAL     | charge recovered (>= UMBRAL_RECUPERACION) or never low
// BAJA       | charge low (<= UMBRAL_BAJO) or in hysteresis band after DESCARGADA
// DESCARGADA | charge is zero
module monitor_baterias_descargadas #(
   parameter int N_BATERIAS          = 2,
   parameter int ANCHO_CARGA         = 4,
   parameter int UMBRAL_BAJO         = 3,
   parameter int UMBRAL_RECUPERACION = 5,
   parameter int CICLOS_FILTRO       = 4
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                habilitar,
   input  logic [N_BATERIAS*ANCHO_CARGA-1:0]   carga_baterias,
   input  logic [N_BATERIAS-1:0]               borrar_alarma,
   output logic [N_BATERIAS-1:0]               advertencia_bateria,
   output logic [N_BATERIAS-1:0]               bateria_baja,
   output logic [N_BATERIAS-1:0]               alarma_retenida,
   output logic                                cualquier_advertencia,
   output logic [$clog2(N_BATERIAS+1)-1:0]     cuenta_descargadas
);

   localparam int CW = $clog2(CICLOS_FILTRO + 1);
   localparam int NW = $clog2(N_BATERIAS + 1);
   localparam logic [CW-1:0]          FILTRO_C = CW'(CICLOS_FILTRO);
   localparam logic [ANCHO_CARGA-1:0] BAJO_C   = ANCHO_CARGA'(UMBRAL_BAJO);
   localparam logic [ANCHO_CARGA-1:0] RECUP_C  = ANCHO_CARGA'(UMBRAL_RECUPERACION);

   typedef enum logic [1:0] {
      NORMAL     = 2'd0,
      BAJA       = 2'd1,
      DESCARGADA = 2'd2
   } estado_t;

   estado_t                r_estado    [N_BATERIAS];
   estado_t                r_candidato [N_BATERIAS];
   logic [CW-1:0]          r_contador  [N_BATERIAS];
   logic [N_BATERIAS-1:0]  r_alarma;

   estado_t                w_estado_sig    [N_BATERIAS];
   estado_t                w_candidato_sig [N_BATERIAS];
   estado_t                w_objetivo      [N_BATERIAS];
   logic [CW-1:0]          w_contador_sig  [N_BATERIAS];
   logic [CW-1:0]          w_contador_inc  [N_BATERIAS];
   logic [ANCHO_CARGA-1:0] w_carga         [N_BATERIAS];
   logic [N_BATERIAS-1:0]  w_alarma_sig;
   logic [NW-1:0]          w_cuenta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_BATERIAS; i++) begin
            r_estado[i]    <= NORMAL;
            r_candidato[i] <= NORMAL;
            r_contador[i]  <= '0;
         end
         r_alarma <= '0;
      end else begin
         for (int i = 0; i < N_BATERIAS; i++) begin
            r_estado[i]    <= w_estado_sig[i];
            r_candidato[i] <= w_candidato_sig[i];
            r_contador[i]  <= w_contador_sig[i];
         end
         r_alarma <= w_alarma_sig;
      end
   end

   always_comb begin
      w_estado_sig    = r_estado;
      w_candidato_sig = r_candidato;
      w_contador_sig  = r_contador;
      w_alarma_sig    = r_alarma;
      for (int i = 0; i < N_BATERIAS; i++) begin
         w_carga[i]        = carga_baterias[i*ANCHO_CARGA +: ANCHO_CARGA];
         w_contador_inc[i] = r_contador[i] + CW'(1);

         if (w_carga[i] == '0)
            w_objetivo[i] = DESCARGADA;
         else if (w_carga[i] <= BAJO_C)
            w_objetivo[i] = BAJA;
         else if (w_carga[i] >= RECUP_C)
            w_objetivo[i] = NORMAL;
         else if (r_estado[i] == DESCARGADA)
            // hysteresis band never holds a channel in DESCARGADA
            w_objetivo[i] = BAJA;
         else
            w_objetivo[i] = r_estado[i];

         if (!habilitar) begin
            w_contador_sig[i] = '0;
         end else if (w_objetivo[i] == r_estado[i]) begin
            w_contador_sig[i] = '0;
         end else if ((w_objetivo[i] != r_candidato[i]) || (r_contador[i] == '0)) begin
            // fresh target: count starts at 1, no credit from a previous target
            w_candidato_sig[i] = w_objetivo[i];
            if (FILTRO_C == CW'(1)) begin
               w_estado_sig[i]   = w_objetivo[i];
               w_contador_sig[i] = '0;
            end else begin
               w_contador_sig[i] = CW'(1);
            end
         end else if (w_contador_inc[i] == FILTRO_C) begin
            w_estado_sig[i]   = r_candidato[i];
            w_contador_sig[i] = '0;
         end else begin
            w_contador_sig[i] = w_contador_inc[i];
         end

         // set has priority over clear on the entry edge
         if ((w_estado_sig[i] == DESCARGADA) && (r_estado[i] != DESCARGADA))
            w_alarma_sig[i] = 1'b1;
         else if (borrar_alarma[i])
            w_alarma_sig[i] = 1'b0;
      end
   end

   always_comb begin
      advertencia_bateria = '0;
      bateria_baja        = '0;
      w_cuenta            = '0;
      for (int i = 0; i < N_BATERIAS; i++) begin
         advertencia_bateria[i] = (r_estado[i] == DESCARGADA);
         bateria_baja[i]        = (r_estado[i] == BAJA);
         w_cuenta               = w_cuenta + NW'(advertencia_bateria[i]);
      end
   end

   assign alarma_retenida       = r_alarma;
   assign cualquier_advertencia = |advertencia_bateria;
   assign cuenta_descargadas    = w_cuenta;

endmodule

// File: tb/tb_monitor_baterias_descargadas.sv
module tb_monitor_baterias_descargadas;

   logic       clk;
   logic       rst_n;
   logic       habilitar;
   logic [7:0] carga_baterias;
   logic [1:0] borrar_alarma;
   logic [1:0] advertencia_bateria;
   logic [1:0] bateria_baja;
   logic [1:0] alarma_retenida;
   logic       cualquier_advertencia;
   logic [1:0] cuenta_descargadas;

   int checks = 0;
   int errors = 0;

   monitor_baterias_descargadas #(
      .N_BATERIAS(2), .ANCHO_CARGA(4), .UMBRAL_BAJO(3),
      .UMBRAL_RECUPERACION(5), .CICLOS_FILTRO(4)
   ) dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .habilitar             (habilitar),
      .carga_baterias        (carga_baterias),
      .borrar_alarma         (borrar_alarma),
      .advertencia_bateria   (advertencia_bateria),
      .bateria_baja          (bateria_baja),
      .alarma_retenida       (alarma_retenida),
      .cualquier_advertencia (cualquier_advertencia),
      .cuenta_descargadas    (cuenta_descargadas)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // compares every output; any/count follow from the expected warning vector
   task automatic estado(input string tag, input logic [1:0] adv,
                         input logic [1:0] baja, input logic [1:0] alarm);
      logic [1:0] n;
      n = {1'b0, adv[0]} + {1'b0, adv[1]};
      chk({tag, ".adv"},   {6'd0, advertencia_bateria},   {6'd0, adv});
      chk({tag, ".baja"},  {6'd0, bateria_baja},          {6'd0, baja});
      chk({tag, ".alarm"}, {6'd0, alarma_retenida},       {6'd0, alarm});
      chk({tag, ".any"},   {7'd0, cualquier_advertencia}, {7'd0, |adv});
      chk({tag, ".cnt"},   {6'd0, cuenta_descargadas},    {6'd0, n});
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic carga(input logic [3:0] c0, input logic [3:0] c1);
      carga_baterias = {c1, c0};
   endtask

   initial begin
      rst_n = 1'b0; habilitar = 1'b1; borrar_alarma = 2'b00; carga(4'd0, 4'd0);
      tick(2);
      estado("reset", 2'b00, 2'b00, 2'b00);

      rst_n = 1'b1;
      tick(3);
      estado("rel3", 2'b00, 2'b00, 2'b00);
      tick(1);
      estado("rel4", 2'b11, 2'b00, 2'b11);

      // debounce and glitch rejection on ch0
      carga(4'd9, 4'd0);
      tick(4);
      estado("ch0_norm", 2'b10, 2'b00, 2'b11);
      borrar_alarma = 2'b01;
      tick(1);
      borrar_alarma = 2'b00;
      estado("clr0", 2'b10, 2'b00, 2'b10);
      carga(4'd0, 4'd0);
      tick(3);
      estado("glitch3", 2'b10, 2'b00, 2'b10);
      carga(4'd9, 4'd0);
      tick(1);
      estado("glitch_back", 2'b10, 2'b00, 2'b10);
      carga(4'd0, 4'd0);
      tick(3);
      estado("zero3", 2'b10, 2'b00, 2'b10);
      tick(1);
      estado("zero4", 2'b11, 2'b00, 2'b11);

      // hysteresis on ch0
      carga(4'd9, 4'd0);
      tick(4);
      estado("back_norm", 2'b10, 2'b00, 2'b11);
      carga(4'd3, 4'd0);
      tick(3);
      estado("low3", 2'b10, 2'b00, 2'b11);
      tick(1);
      estado("low4", 2'b10, 2'b01, 2'b11);
      carga(4'd4, 4'd0);
      tick(10);
      estado("band", 2'b10, 2'b01, 2'b11);
      carga(4'd5, 4'd0);
      tick(3);
      estado("rec3", 2'b10, 2'b01, 2'b11);
      tick(1);
      estado("rec4", 2'b10, 2'b00, 2'b11);

      // ch1 leaves DESCARGADA through the band into BAJA
      carga(4'd5, 4'd4);
      tick(3);
      estado("ch1_band3", 2'b10, 2'b00, 2'b11);
      tick(1);
      estado("ch1_band4", 2'b00, 2'b10, 2'b11);
      borrar_alarma = 2'b10;
      tick(1);
      borrar_alarma = 2'b00;
      estado("clr1", 2'b00, 2'b10, 2'b01);
      tick(1);
      estado("clr1_hold", 2'b00, 2'b10, 2'b01);

      // set wins over clear on the entry edge
      borrar_alarma = 2'b01;
      tick(1);
      borrar_alarma = 2'b00;
      estado("clr0b", 2'b00, 2'b10, 2'b00);
      carga(4'd0, 4'd4);
      tick(3);
      estado("coll3", 2'b00, 2'b10, 2'b00);
      borrar_alarma = 2'b01;
      tick(1);
      estado("coll_entry", 2'b01, 2'b10, 2'b01);
      tick(1);
      estado("clr_in_D", 2'b01, 2'b10, 2'b00);
      borrar_alarma = 2'b00;
      tick(1);
      estado("no_reset", 2'b01, 2'b10, 2'b00);

      // enable drop mid-count restarts the filter; DESCARGADA -> NORMAL directly
      carga(4'd9, 4'd4);
      tick(2);
      estado("en_pre", 2'b01, 2'b10, 2'b00);
      habilitar = 1'b0;
      tick(2);
      estado("en_off", 2'b01, 2'b10, 2'b00);
      habilitar = 1'b1;
      tick(3);
      estado("en_on3", 2'b01, 2'b10, 2'b00);
      tick(1);
      estado("en_on4", 2'b00, 2'b10, 2'b00);

      // asynchronous reset between edges
      carga(4'd0, 4'd4);
      tick(4);
      estado("pre_async", 2'b01, 2'b10, 2'b01);
      #3;
      rst_n = 1'b0;
      #1;
      estado("async", 2'b00, 2'b00, 2'b00);

      // reset mid-debounce discards the partial count
      carga(4'd0, 4'd0);
      tick(1);
      rst_n = 1'b1;
      tick(2);
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      tick(3);
      estado("mid_rst3", 2'b00, 2'b00, 2'b00);
      tick(1);
      estado("mid_rst4", 2'b11, 2'b00, 2'b11);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
